// File: rtl/aes_128_arbiter_pkg.sv
// Shared types and constants for the AES-128 core arbiter.
package aes_arb_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int AES_LATENCY_DEF = 20;

    // Index field is wide enough for the largest supported requester count (8).
    localparam int TAG_IDX_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RUN,
        ARB_DRAIN
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } arb_tag_t;

endpackage

// File: rtl/aes_128_arbiter_if.sv
// Requester-side bus of the AES arbiter: packed request lanes plus one-hot response.
interface aes_128_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import aes_arb_pkg::*;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*AES_BLK_W-1:0] req_state;
    logic [NUM_REQ*AES_BLK_W-1:0] req_key;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [AES_BLK_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_state, req_key,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_state, req_key,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/aes_128_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        int unsigned pos;
        pos   = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[pos[IDX_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos[IDX_W-1:0];
            end
        end
        if (any_o) gnt_o = NUM_REQ'(1) << idx_o;
    end

endmodule

// File: rtl/aes_128_arbiter.sv
// Shares one pipelined AES-128 core between NUM_REQ requesters.
// Round-robin issue, tag pipeline matched to core latency, drain/quiesce FSM.
// Optional AES_ARB_ZEROIZE_EN: clear core inputs in every non-accept cycle.
module aes_128_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int AES_LATENCY = AES_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 drain_req,
    output logic                 idle,
    aes_128_arbiter_if.slave     req_if,
    output logic [AES_BLK_W-1:0] aes_state,
    output logic [AES_BLK_W-1:0] aes_key,
    input  logic [AES_BLK_W-1:0] aes_out
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam int               INF_W   = $clog2(AES_LATENCY + 2);
    localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(AES_LATENCY + 1);

    arb_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [INF_W-1:0]                  inflight_q, inflight_d;
    logic [AES_BLK_W-1:0]              aes_state_q, aes_state_d;
    logic [AES_BLK_W-1:0]              aes_key_q, aes_key_d;
    arb_tag_t [AES_LATENCY:0]          tag_q;
    arb_tag_t                          tag_in, tag_out;

    logic [NUM_REQ-1:0]                gnt;
    logic [IDX_W-1:0]                  gnt_idx;
    logic                              gnt_any, run, accept, retire;
    logic [NUM_REQ-1:0][AES_BLK_W-1:0] st_arr, ky_arr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (req_if.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign run              = (state_q == ARB_RUN);
    assign accept           = run & gnt_any;
    assign req_if.req_ready = run ? gnt : '0;
    assign st_arr           = req_if.req_state;
    assign ky_arr           = req_if.req_key;

    // Tag enters with the accept and leaves the cycle the core shows its result.
    assign tag_in.valid     = accept;
    assign tag_in.idx       = TAG_IDX_W'(gnt_idx);
    assign tag_out          = tag_q[AES_LATENCY];
    assign retire           = tag_out.valid;
    assign req_if.rsp_valid = retire ? (NUM_REQ'(1) << tag_out.idx) : '0;
    assign req_if.rsp_data  = aes_out;

    assign aes_state        = aes_state_q;
    assign aes_key          = aes_key_q;
    assign idle             = (state_q == ARB_IDLE) && (inflight_q == '0);

    // Issue-control FSM; DRAIN only exits to IDLE once the core is empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (enable && !drain_req)          state_d = ARB_RUN;
            ARB_RUN:   if (drain_req || !enable)          state_d = ARB_DRAIN;
            ARB_DRAIN: if (inflight_q == '0 && !accept)   state_d = ARB_IDLE;
            default:                                      state_d = ARB_IDLE;
        endcase
    end

    // Next values for core inputs, rr pointer and in-flight count.
    always_comb begin
        aes_state_d = aes_state_q;
        aes_key_d   = aes_key_q;
        rr_ptr_d    = rr_ptr_q;
        inflight_d  = inflight_q;
        if (accept) begin
            aes_state_d = st_arr[gnt_idx];
            aes_key_d   = ky_arr[gnt_idx];
            rr_ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
`ifdef AES_ARB_ZEROIZE_EN
        // Covers the DRAIN->IDLE edge too, since no accept happens there.
        else begin
            aes_state_d = '0;
            aes_key_d   = '0;
        end
`endif
        case ({accept, retire})
            2'b10:   inflight_d = inflight_q + INF_ONE;
            2'b01:   inflight_d = inflight_q - INF_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            aes_state_q <= '0;
            aes_key_q   <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            aes_state_q <= aes_state_d;
            aes_key_q   <= aes_key_d;
            tag_q       <= {tag_q[AES_LATENCY-1:0], tag_in};
        end
    end

    // The counter can hold at most one block per tag stage and never goes negative.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(accept && !retire && inflight_q == INF_MAX))
                else $error("inflight counter overflow");
            assert (!(retire && !accept && inflight_q == '0))
                else $error("inflight counter underflow");
        end
    end

endmodule

// File: tb/tb_aes_128_arbiter.sv
// Bench for aes_128_arbiter: behavioural core stub, reference model scoreboard,
// and directed scenario tasks. Honors AES_ARB_ZEROIZE_EN for core-input expectations.
module tb_aes_128_arbiter;
    import aes_arb_pkg::*;

    localparam int N   = 4;
    localparam int L   = 20;
    localparam int LAT = L + 1;

    localparam logic [127:0] KAT0_S = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] KAT0_K = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] KAT0_C = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] KAT1_S = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] KAT1_K = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] KAT1_C = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] KAT2_C = 128'h66e94bd4_ef8a2c3b_884cfa59_ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         drain_req = 1'b0;
    logic         idle;
    logic [127:0] aes_state, aes_key, aes_out;
    logic [N-1:0][127:0] tb_st, tb_ky;

    int n_vec = 0;
    int n_err = 0;

    aes_128_arbiter_if #(.NUM_REQ(N)) bus ();
    assign bus.req_state = tb_st;
    assign bus.req_key   = tb_ky;

    aes_128_arbiter #(.NUM_REQ(N), .AES_LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .drain_req (drain_req),
        .idle      (idle),
        .req_if    (bus),
        .aes_state (aes_state),
        .aes_key   (aes_key),
        .aes_out   (aes_out)
    );

    always #5 clk = ~clk;

    // Core stand-in: known-answer vectors, otherwise an arbitrary keyed mix.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
        if (s == KAT0_S && k == KAT0_K) return KAT0_C;
        if (s == KAT1_S && k == KAT1_K) return KAT1_C;
        if (s == '0 && k == '0)         return KAT2_C;
        return (s ^ {k[63:0], k[127:64]}) + 128'h9e3779b9_7f4a7c15_0badf00d_12345678;
    endfunction

    // Core samples its inputs on the edge after the accept, result shows L edges later.
    logic [255:0] core_pipe [L];
    always @(posedge clk) begin
        core_pipe[0] <= {aes_state, aes_key};
        for (int k = 1; k < L; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign aes_out = core_f(core_pipe[L-1][255:128], core_pipe[L-1][127:0]);

    function automatic logic [N-1:0] one_hot(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        int           idx;
        logic [127:0] data;
    } exp_t;

    exp_t         q[$];
    int           m_mode = 0;     // 0 idle, 1 run, 2 drain
    int           m_ptr = 0;
    int           m_inflight = 0;
    int           m_gnt = -1;
    int           cyc = 0;
    logic [127:0] m_st = '0;
    logic [127:0] m_ky = '0;

    initial begin : monitor
        logic [N-1:0] exp_ready, exp_rv;
        logic [127:0] exp_rd;
        bit           has_rsp, acc;
        int           nm;
        forever begin
            @(negedge clk);
            m_gnt   = -1;
            has_rsp = 1'b0;
            if (rst_n) begin
                if (m_mode == 1)
                    for (int k = 0; k < N; k++)
                        if (m_gnt < 0 && bus.req_valid[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
                exp_ready = (m_gnt >= 0) ? one_hot(m_gnt) : '0;
                has_rsp   = (q.size() > 0) && (q[0].due == cyc);
                exp_rv    = has_rsp ? one_hot(q[0].idx) : '0;
                exp_rd    = has_rsp ? q[0].data : '0;
                n_vec++;
                if (bus.req_ready !== exp_ready) begin
                    n_err++;
                    $display("FAIL mon_ready cyc=%0d got %b exp %b", cyc, bus.req_ready, exp_ready);
                end
                n_vec++;
                if (bus.rsp_valid !== exp_rv) begin
                    n_err++;
                    $display("FAIL mon_rsp_valid cyc=%0d got %b exp %b", cyc, bus.rsp_valid, exp_rv);
                end
                if (has_rsp) begin
                    n_vec++;
                    if (bus.rsp_data !== exp_rd) begin
                        n_err++;
                        $display("FAIL mon_rsp_data cyc=%0d got %h exp %h", cyc, bus.rsp_data, exp_rd);
                    end
                end
                n_vec++;
                if (idle !== (m_mode == 0 && m_inflight == 0)) begin
                    n_err++;
                    $display("FAIL mon_idle cyc=%0d got %b exp %b", cyc, idle, (m_mode == 0 && m_inflight == 0));
                end
                n_vec++;
                if (aes_state !== m_st || aes_key !== m_ky) begin
                    n_err++;
                    $display("FAIL mon_core_in cyc=%0d got %h/%h exp %h/%h", cyc, aes_state, aes_key, m_st, m_ky);
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_mode = 0; m_ptr = 0; m_inflight = 0; m_st = '0; m_ky = '0;
            end else begin
                acc = (m_gnt >= 0);
                if (has_rsp) void'(q.pop_front());
                nm = m_mode;
                case (m_mode)
                    0: if (enable && !drain_req)      nm = 1;
                    1: if (drain_req || !enable)      nm = 2;
                    default: if (m_inflight == 0 && !acc) nm = 0;
                endcase
                m_mode     = nm;
                m_inflight = m_inflight + (acc ? 1 : 0) - (has_rsp ? 1 : 0);
                if (acc) begin
                    m_st  = tb_st[m_gnt];
                    m_ky  = tb_ky[m_gnt];
                    m_ptr = (m_gnt + 1) % N;
                    q.push_back('{due: cyc + LAT, idx: m_gnt, data: core_f(tb_st[m_gnt], tb_ky[m_gnt])});
                end else begin
`ifdef AES_ARB_ZEROIZE_EN
                    m_st = '0;
                    m_ky = '0;
`endif
                end
            end
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
            n_err++;
            $display("FAIL reset_hs got ready=%b rsp=%b exp 0/0", bus.req_ready, bus.rsp_valid);
        end
        n_vec++;
        if (idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle got %b exp 1", idle);
        end
        n_vec++;
        if (aes_state !== '0 || aes_key !== '0) begin
            n_err++;
            $display("FAIL reset_core_in got %h/%h exp 0/0", aes_state, aes_key);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        enable = 1'b1;
        bus.req_valid = '0;
        next_cycle();
        for (int i = 0; i < N; i++) begin
            tb_st[i] = rnd128();
            tb_ky[i] = rnd128();
        end
        tb_st[1] = KAT1_S;
        tb_ky[1] = KAT1_K;
        bus.req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = one_hot(c % N);
            n_vec++;
            if (bus.req_ready !== exp) begin
                n_err++;
                $display("FAIL rr_grant c=%0d got %b exp %b", c, bus.req_ready, exp);
            end
            next_cycle();
        end
        bus.req_valid = '0;
        repeat (LAT - 8) next_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = one_hot(c % N);
            n_vec++;
            if (bus.rsp_valid !== exp) begin
                n_err++;
                $display("FAIL rr_rsp_order c=%0d got %b exp %b", c, bus.rsp_valid, exp);
            end
            if (c % N == 1) begin
                n_vec++;
                if (bus.rsp_data !== KAT1_C) begin
                    n_err++;
                    $display("FAIL rr_rsp_kat1 c=%0d got %h exp %h", c, bus.rsp_data, KAT1_C);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        logic [127:0] hold_s, hold_k;
`ifdef AES_ARB_ZEROIZE_EN
        hold_s = '0;
        hold_k = '0;
`else
        hold_s = KAT0_S;
        hold_k = KAT0_K;
`endif
        tb_st[0] = KAT0_S;
        tb_ky[0] = KAT0_K;
        bus.req_valid = 4'b0001;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_vec++;
                if (bus.req_ready !== 4'b0001) begin
                    n_err++;
                    $display("FAIL single_grant got %b exp 0001", bus.req_ready);
                end
            end
            if (c == 1) begin
                n_vec++;
                if (aes_state !== KAT0_S || aes_key !== KAT0_K) begin
                    n_err++;
                    $display("FAIL single_core_in got %h/%h exp %h/%h", aes_state, aes_key, KAT0_S, KAT0_K);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (aes_state !== hold_s || aes_key !== hold_k) begin
                    n_err++;
                    $display("FAIL idle_core_in got %h/%h exp %h/%h", aes_state, aes_key, hold_s, hold_k);
                end
            end
            if (c >= 1 && c < LAT) begin
                n_vec++;
                if (bus.rsp_valid !== '0) begin
                    n_err++;
                    $display("FAIL single_early_rsp c=%0d got %b exp 0000", c, bus.rsp_valid);
                end
            end
            if (c == LAT) begin
                n_vec++;
                if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== KAT0_C) begin
                    n_err++;
                    $display("FAIL single_rsp got %b/%h exp 0001/%h", bus.rsp_valid, bus.rsp_data, KAT0_C);
                end
            end
            next_cycle();
            if (c == 0) bus.req_valid = '0;
        end
    endtask

    task automatic test_back_to_back();
        tb_st[2] = '0;
        tb_ky[2] = '0;
        bus.req_valid = 4'b0100;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            if (c < 3) begin
                n_vec++;
                if (bus.req_ready !== 4'b0100) begin
                    n_err++;
                    $display("FAIL b2b_grant c=%0d got %b exp 0100", c, bus.req_ready);
                end
            end else if (c >= LAT && c < LAT + 3) begin
                n_vec++;
                if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== KAT2_C) begin
                    n_err++;
                    $display("FAIL b2b_rsp c=%0d got %b/%h exp 0100/%h", c, bus.rsp_valid, bus.rsp_data, KAT2_C);
                end
            end else begin
                n_vec++;
                if (bus.rsp_valid !== '0) begin
                    n_err++;
                    $display("FAIL b2b_quiet c=%0d got %b exp 0000", c, bus.rsp_valid);
                end
            end
            next_cycle();
            if (c == 2) bus.req_valid = '0;
        end
    endtask

    task automatic test_drain();
        int n_rsp = 0;
        for (int i = 0; i < N; i++) begin
            tb_st[i] = rnd128();
            tb_ky[i] = rnd128();
        end
        bus.req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            drain_req = (c >= 5);
            @(negedge clk);
            n_rsp += $countones(bus.rsp_valid);
            if (c >= 6) begin
                n_vec++;
                if (bus.req_ready !== '0) begin
                    n_err++;
                    $display("FAIL drain_ready c=%0d got %b exp 0000", c, bus.req_ready);
                end
            end
            n_vec++;
            if (idle !== (c >= 28)) begin
                n_err++;
                $display("FAIL drain_idle c=%0d got %b exp %b", c, idle, (c >= 28));
            end
            next_cycle();
        end
        n_vec++;
        if (n_rsp != 6) begin
            n_err++;
            $display("FAIL drain_rsp_count got %0d exp 6", n_rsp);
        end
        drain_req = 1'b0;
        bus.req_valid = '0;
        next_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                tb_st[i] = rnd128();
                tb_ky[i] = rnd128();
            end
            enable    = ($urandom_range(0, 19) != 0);
            drain_req = ($urandom_range(0, 24) == 0);
            next_cycle();
        end
        enable = 1'b1;
        drain_req = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        enable = 1'b1;
        drain_req = 1'b0;
        bus.req_valid = '0;
        repeat (40) next_cycle();
        for (int i = 0; i < N; i++) begin
            tb_st[i] = rnd128();
            tb_ky[i] = rnd128();
        end
        bus.req_valid = '1;
        repeat (10) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== '0 || idle !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ctl got ready=%b rsp=%b idle=%b exp 0000/0000/1", bus.req_ready, bus.rsp_valid, idle);
        end
        n_vec++;
        if (aes_state !== '0 || aes_key !== '0) begin
            n_err++;
            $display("FAIL midrst_core_in got %h/%h exp 0/0", aes_state, aes_key);
        end
        bus.req_valid = '0;
        enable = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.rsp_valid !== '0 || idle !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_after c=%0d got rsp=%b idle=%b exp 0000/1", c, bus.rsp_valid, idle);
            end
            next_cycle();
        end
    endtask

    initial begin
        bus.req_valid = '0;
        tb_st = '0;
        tb_ky = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_back_to_back();
        test_drain();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
